// File: rtl/button_debouncer_pkg.sv
// Shared definitions for the push-button debouncer: FSM state encoding and
// a constant-function log2 used to size the per-bit counters.
package button_debouncer_pkg;

  typedef enum logic [1:0] {
    StReleased    = 2'd0,
    StWaitPress   = 2'd1,
    StPressed     = 2'd2,
    StWaitRelease = 2'd3
  } deb_state_e;

  // Ceiling log2; callers guarantee value >= 2.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    result = 0;
    for (int i = 0; i < 32; i++) begin
      if (((value - 1) >> i) != 0) result = i + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/button_debounce_bit.sv
// One debounced button in active-high "pressed" polarity: 2-flop synchronizer,
// debounce FSM, debounce and long-press counters, registered event outputs.
module button_debounce_bit
  import button_debouncer_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES   = 500000,
  parameter int unsigned LONG_PRESS_CYCLES = 50000000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic pressed_raw,
  output logic pressed,
  output logic press_pulse,
  output logic release_pulse,
  output logic long_press
);

  localparam int unsigned DcntW = clog2(DEBOUNCE_CYCLES);
  localparam int unsigned LcntW = clog2(LONG_PRESS_CYCLES);
  localparam logic [DcntW-1:0] DcntLast = DcntW'(DEBOUNCE_CYCLES - 1);
  localparam logic [LcntW-1:0] LcntLast = LcntW'(LONG_PRESS_CYCLES - 1);

  logic [1:0]       sync_q;
  logic             sync;
  deb_state_e       state_q, state_d;
  logic [DcntW-1:0] dcnt_q, dcnt_d;
  logic [LcntW-1:0] lcnt_q, lcnt_d;
  logic             lfired_q, lfired_d;
  logic             pressed_q, pressed_d;
  logic             press_q, press_d;
  logic             release_q, release_d;
  logic             long_q, long_d;

  assign sync = sync_q[1];

  always_comb begin
    state_d  = state_q;
    dcnt_d   = dcnt_q;
    lcnt_d   = lcnt_q;
    lfired_d = lfired_q;
    long_d   = 1'b0;

    case (state_q)
      StReleased: begin
        if (sync) begin
          state_d = StWaitPress;
          dcnt_d  = '0;
        end
      end
      StWaitPress: begin
        if (!sync) begin
          state_d = StReleased;
          dcnt_d  = '0;
        end else if (dcnt_q == DcntLast) begin
          state_d  = StPressed;
          dcnt_d   = '0;
          lcnt_d   = '0;
          lfired_d = 1'b0;
        end else begin
          dcnt_d = dcnt_q + 1'b1;
        end
      end
      StPressed: begin
        if (!sync) begin
          state_d = StWaitRelease;
          dcnt_d  = '0;
        end
      end
      StWaitRelease: begin
        if (sync) begin
          state_d = StPressed;
          dcnt_d  = '0;
        end else if (dcnt_q == DcntLast) begin
          state_d  = StReleased;
          dcnt_d   = '0;
          lcnt_d   = '0;
          lfired_d = 1'b0;
        end else begin
          dcnt_d = dcnt_q + 1'b1;
        end
      end
      default: state_d = StReleased;
    endcase

    // Long-press timing keeps running through release glitches; an accepted
    // release in this cycle wins and suppresses any pulse.
    if ((state_q == StPressed || state_q == StWaitRelease) && state_d != StReleased) begin
      if (lcnt_q != LcntLast) begin
        lcnt_d = lcnt_q + 1'b1;
      end else if (!lfired_q) begin
        long_d   = 1'b1;
        lfired_d = 1'b1;
      end
    end

    pressed_d = (state_d == StPressed) || (state_d == StWaitRelease);
    press_d   = pressed_d & ~pressed_q;
    release_d = ~pressed_d & pressed_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q    <= '0;
      state_q   <= StReleased;
      dcnt_q    <= '0;
      lcnt_q    <= '0;
      lfired_q  <= 1'b0;
      pressed_q <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      long_q    <= 1'b0;
    end else begin
      sync_q    <= {sync_q[0], pressed_raw};
      state_q   <= state_d;
      dcnt_q    <= dcnt_d;
      lcnt_q    <= lcnt_d;
      lfired_q  <= lfired_d;
      pressed_q <= pressed_d;
      press_q   <= press_d;
      release_q <= release_d;
      long_q    <= long_d;
    end
  end

  assign pressed       = pressed_q;
  assign press_pulse   = press_q;
  assign release_pulse = release_q;
  assign long_press    = long_q;

endmodule

// File: rtl/button_debouncer.sv
// Push-button debouncer bank: maps board polarity to active-high pressed
// levels and instantiates one debounce slice per button.
module button_debouncer #(
  parameter int unsigned WIDTH             = 1,
  parameter int unsigned DEBOUNCE_CYCLES   = 500000,
  parameter int unsigned LONG_PRESS_CYCLES = 50000000,
  parameter bit          ACTIVE_LOW        = 1'b1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] btn_raw,
  output logic [WIDTH-1:0] btn_out,
  output logic [WIDTH-1:0] press_pulse,
  output logic [WIDTH-1:0] release_pulse,
  output logic [WIDTH-1:0] long_press
);

  localparam logic [WIDTH-1:0] PolMask = ACTIVE_LOW ? {WIDTH{1'b1}} : {WIDTH{1'b0}};

  logic [WIDTH-1:0] raw_pressed;
  logic [WIDTH-1:0] deb_pressed;

  assign raw_pressed = btn_raw ^ PolMask;
  // Inversion of a flop output only; no path from btn_raw to any output.
  assign btn_out     = deb_pressed ^ PolMask;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    button_debounce_bit #(
      .DEBOUNCE_CYCLES  (DEBOUNCE_CYCLES),
      .LONG_PRESS_CYCLES(LONG_PRESS_CYCLES)
    ) u_bit (
      .clk          (clk),
      .reset_n      (reset_n),
      .pressed_raw  (raw_pressed[i]),
      .pressed      (deb_pressed[i]),
      .press_pulse  (press_pulse[i]),
      .release_pulse(release_pulse[i]),
      .long_press   (long_press[i])
    );
  end

endmodule

// File: tb/tb_button_debouncer.sv
// Directed bench for button_debouncer with WIDTH=2, DEBOUNCE_CYCLES=4,
// LONG_PRESS_CYCLES=10, ACTIVE_LOW=1.
module tb_button_debouncer;

  logic       clk;
  logic       reset_n;
  logic [1:0] btn_raw;
  logic [1:0] btn_out;
  logic [1:0] press_pulse;
  logic [1:0] release_pulse;
  logic [1:0] long_press;

  int n_cmp;
  int n_err;

  button_debouncer #(
    .WIDTH            (2),
    .DEBOUNCE_CYCLES  (4),
    .LONG_PRESS_CYCLES(10),
    .ACTIVE_LOW       (1'b1)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .btn_raw      (btn_raw),
    .btn_out      (btn_out),
    .press_pulse  (press_pulse),
    .release_pulse(release_pulse),
    .long_press   (long_press)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [1:0] got, input logic [1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance n rising edges, ending 1 time unit after the last one.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_idle(input string tag, input logic [1:0] lvl);
    check_eq({tag, "_out"}, btn_out, lvl);
    check_eq({tag, "_press"}, press_pulse, 2'b00);
    check_eq({tag, "_rel"}, release_pulse, 2'b00);
    check_eq({tag, "_long"}, long_press, 2'b00);
  endtask

  initial begin
    n_cmp   = 0;
    n_err   = 0;
    reset_n = 1'b1;
    btn_raw = 2'b11;

    // Asynchronous reset asserted mid-cycle
    #12;
    reset_n = 1'b0;
    #1;
    check_idle("rst_async", 2'b11);
    tick(2);
    check_idle("rst_held", 2'b11);
    reset_n = 1'b1;
    tick(3);
    check_idle("rst_after", 2'b11);

    // Clean press on bit 0: first sample at edge 1, change at edge 7
    btn_raw = 2'b10;
    for (int i = 1; i <= 6; i++) begin
      tick(1);
      check_idle("press_wait", 2'b11);
    end
    tick(1);
    check_eq("press_out", btn_out, 2'b10);
    check_eq("press_pulse", press_pulse, 2'b01);
    check_eq("press_rel", release_pulse, 2'b00);
    tick(1);
    check_eq("press_pulse_end", press_pulse, 2'b00);
    check_eq("press_hold_out", btn_out, 2'b10);

    // Long press: 10 edges after press_pulse
    for (int i = 2; i <= 9; i++) begin
      tick(1);
      check_eq("long_early", long_press, 2'b00);
    end
    tick(1);
    check_eq("long_pulse", long_press, 2'b01);
    tick(1);
    check_eq("long_end", long_press, 2'b00);
    for (int i = 0; i < 30; i++) begin
      tick(1);
      check_eq("long_once", long_press, 2'b00);
    end
    check_eq("long_hold_out", btn_out, 2'b10);

    // Clean release
    btn_raw = 2'b11;
    for (int i = 1; i <= 6; i++) begin
      tick(1);
      check_eq("rel_wait_out", btn_out, 2'b10);
      check_eq("rel_wait_pulse", release_pulse, 2'b00);
    end
    tick(1);
    check_eq("rel_out", btn_out, 2'b11);
    check_eq("rel_pulse", release_pulse, 2'b01);
    check_eq("rel_press", press_pulse, 2'b00);
    tick(1);
    check_eq("rel_pulse_end", release_pulse, 2'b00);
    tick(4);

    // Bounce: low 3, high 1, then low held; change 7 edges after final low set
    btn_raw = 2'b10;
    tick(3);
    check_idle("bounce_a", 2'b11);
    btn_raw = 2'b11;
    tick(1);
    check_idle("bounce_b", 2'b11);
    btn_raw = 2'b10;
    for (int i = 1; i <= 6; i++) begin
      tick(1);
      check_idle("bounce_wait", 2'b11);
    end
    tick(1);
    check_eq("bounce_out", btn_out, 2'b10);
    check_eq("bounce_press", press_pulse, 2'b01);

    // Release glitch of 2 cycles: no release, long_press still 10 edges after press
    tick(1);
    btn_raw = 2'b11;
    tick(2);
    btn_raw = 2'b10;
    for (int i = 4; i <= 9; i++) begin
      tick(1);
      check_eq("glitch_out", btn_out, 2'b10);
      check_eq("glitch_rel", release_pulse, 2'b00);
      check_eq("glitch_long_early", long_press, 2'b00);
    end
    tick(1);
    check_eq("glitch_long", long_press, 2'b01);
    check_eq("glitch_long_out", btn_out, 2'b10);
    tick(1);
    check_eq("glitch_long_end", long_press, 2'b00);

    btn_raw = 2'b11;
    tick(7);
    check_eq("glitch_final_rel", release_pulse, 2'b01);
    check_eq("glitch_final_out", btn_out, 2'b11);
    tick(4);

    // Reset two cycles into WAIT_PRESS with the button still held
    btn_raw = 2'b10;
    tick(5);
    check_idle("rstwp_before", 2'b11);
    #3;
    reset_n = 1'b0;
    #1;
    check_idle("rstwp_async", 2'b11);
    tick(2);
    check_idle("rstwp_held", 2'b11);
    reset_n = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      tick(1);
      check_idle("rstwp_wait", 2'b11);
    end
    tick(1);
    check_eq("rstwp_out", btn_out, 2'b10);
    check_eq("rstwp_press", press_pulse, 2'b01);
    tick(1);
    check_eq("rstwp_press_end", press_pulse, 2'b00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
